// File: rtl/adder_pkg.sv
// Shared constants and types for the carry-lookahead adder.
package adder_pkg;

    localparam int CLA_GROUP = 4;

    // Number of 4-bit lookahead groups needed to cover a width.
    function automatic int group_count(input int width);
        return (width + CLA_GROUP - 1) / CLA_GROUP;
    endfunction

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/adder_cla4.sv
// One 4-bit carry-lookahead group: bit sums plus group generate/propagate.
module adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g,
    output logic       p,
    output logic       cout
);

    logic [3:0] g_bit;
    logic [3:0] p_bit;
    logic [3:0] c;

    assign g_bit = a & b;
    assign p_bit = a ^ b;

    // Internal carries fully expanded so no carry ripples inside the group.
    assign c[0] = cin;
    assign c[1] = g_bit[0] | (p_bit[0] & cin);
    assign c[2] = g_bit[1] | (p_bit[1] & g_bit[0]) | (p_bit[1] & p_bit[0] & cin);
    assign c[3] = g_bit[2] | (p_bit[2] & g_bit[1]) | (p_bit[2] & p_bit[1] & g_bit[0])
                | (p_bit[2] & p_bit[1] & p_bit[0] & cin);

    assign g = g_bit[3] | (p_bit[3] & g_bit[2]) | (p_bit[3] & p_bit[2] & g_bit[1])
             | (p_bit[3] & p_bit[2] & p_bit[1] & g_bit[0]);
    assign p = &p_bit;

    assign cout = g | (p & cin);
    assign sum  = p_bit ^ c;

endmodule

// File: rtl/adder.sv
// B-bit adder with carry-in, carry-out and signed overflow, built from 4-bit CLA groups.
// Define ADDER_REG_OUT_EN to register s/cout/ovf on clk (sync active-high rst clears them).
module adder
    import adder_pkg::*;
#(
    parameter int B = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    input  logic         cin,
    output logic [B-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int NG = group_count(B);
    localparam int WP = NG * CLA_GROUP;

    logic [WP-1:0]   a_pad;
    logic [WP-1:0]   b_pad;
    logic [WP-1:0]   sum_pad;
    logic [WP:0]     full_pad;
    logic [NG:0]     carry;
    gp_t  [NG-1:0]   gp;
    logic [NG-1:0]   unused_cout;
    logic [B-1:0]    s_c;
    logic            cout_c;
    logic            ovf_c;

    assign a_pad    = WP'(a);
    assign b_pad    = WP'(b);
    assign carry[0] = cin;

    for (genvar i = 0; i < NG; i++) begin : g_grp
        adder_cla4 u_cla (
            .a    (a_pad[i*CLA_GROUP +: CLA_GROUP]),
            .b    (b_pad[i*CLA_GROUP +: CLA_GROUP]),
            .cin  (carry[i]),
            .sum  (sum_pad[i*CLA_GROUP +: CLA_GROUP]),
            .g    (gp[i].g),
            .p    (gp[i].p),
            .cout (unused_cout[i])
        );
        assign carry[i+1] = gp[i].g | (gp[i].p & carry[i]);
    end

    // Padding bits are zero, so in a partial final group the sum bit at
    // position B is exactly the carry out of bit B-1.
    assign full_pad = {carry[NG], sum_pad};
    assign s_c      = full_pad[B-1:0];
    assign cout_c   = full_pad[B];
    assign ovf_c    = (a[B-1] == b[B-1]) && (s_c[B-1] != a[B-1]);

    if (WP > B) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^full_pad[WP:B+1];
    end

`ifdef ADDER_REG_OUT_EN
    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            s    <= s_c;
            cout <= cout_c;
            ovf  <= ovf_c;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk ^ rst;

    assign s    = s_c;
    assign cout = cout_c;
    assign ovf  = ovf_c;
`endif

endmodule

// File: tb/tb_adder.sv
// Directed and random bench for adder at B = 12, 1 and 13; follows ADDER_REG_OUT_EN.
module tb_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [11:0] a12 = '0, b12 = '0, s12;
    logic        ci12 = 1'b0, co12, ov12;
    logic        a1 = 1'b0, b1 = 1'b0, s1;
    logic        ci1 = 1'b0, co1, ov1;
    logic [12:0] a13 = '0, b13 = '0, s13;
    logic        ci13 = 1'b0, co13, ov13;

    int n_checks = 0;
    int n_errors = 0;
    logic [13:0] prev12 = '0;

    adder #(.B(12)) dut (.clk(clk), .rst(rst), .a(a12), .b(b12), .cin(ci12),
                         .s(s12), .cout(co12), .ovf(ov12));
    adder #(.B(1)) dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .cin(ci1),
                         .s(s1), .cout(co1), .ovf(ov1));
    adder #(.B(13)) dut13 (.clk(clk), .rst(rst), .a(a13), .b(b13), .cin(ci13),
                           .s(s13), .cout(co13), .ovf(ov13));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
`ifdef ADDER_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // Directed vector on the B=12 instance; expected values given by hand.
    task automatic vec12(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic cin, input logic [11:0] es, input logic ec, input logic eo);
        a12  = a;
        b12  = b;
        ci12 = cin;
`ifdef ADDER_REG_OUT_EN
        #1;
        check({tag, "_lag"}, {50'd0, ov12, co12, s12}, {50'd0, prev12});
`endif
        settle();
        check(tag, {50'd0, ov12, co12, s12}, {50'd0, eo, ec, es});
        prev12 = {eo, ec, es};
    endtask

    function automatic logic [13:0] model12(input logic [11:0] a, input logic [11:0] b, input logic c);
        logic [12:0] f;
        f = {1'b0, a} + {1'b0, b} + {12'd0, c};
        return {(a[11] == b[11]) && (f[11] != a[11]), f};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
        logic [1:0] f;
        f = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return {(a == b) && (f[0] != a), f};
    endfunction

    function automatic logic [14:0] model13(input logic [12:0] a, input logic [12:0] b, input logic c);
        logic [13:0] f;
        f = {1'b0, a} + {1'b0, b} + {13'd0, c};
        return {(a[12] == b[12]) && (f[12] != a[12]), f};
    endfunction

    initial begin
        // Operands change while reset is held.
        a12 = 12'd5;
        b12 = 12'd7;
        repeat (2) @(posedge clk);
        #1;
`ifdef ADDER_REG_OUT_EN
        check("reset_state", {50'd0, ov12, co12, s12}, 64'd0);
`else
        check("reset_ignored", {50'd0, ov12, co12, s12}, 64'd12);
`endif
        rst = 1'b0;

        vec12("small",      12'd12,   12'd13,   1'b0, 12'd25,   1'b0, 1'b0);
        vec12("zero_a",     12'd0,    12'd1213, 1'b0, 12'd1213, 1'b0, 1'b0);
        vec12("zero_b",     12'd192,  12'd0,    1'b0, 12'd192,  1'b0, 1'b0);
        vec12("mix_pos",    12'd232,  12'd4064, 1'b0, 12'd200,  1'b1, 1'b0);
        vec12("mix_neg",    12'd3196, 12'd1000, 1'b0, 12'd100,  1'b1, 1'b0);
        vec12("cancel",     12'd54,   12'd4042, 1'b0, 12'd0,    1'b1, 1'b0);
        vec12("cancel_ci",  12'd54,   12'd4042, 1'b1, 12'd1,    1'b1, 1'b0);
        vec12("cancel_2",   12'd54,   12'd4042, 1'b0, 12'd0,    1'b1, 1'b0);
        vec12("both_neg",   12'd3864, 12'd4064, 1'b0, 12'd3832, 1'b1, 1'b0);
        vec12("all_ones",   12'd4095, 12'd0,    1'b0, 12'd4095, 1'b0, 1'b0);
        vec12("wrap",       12'd4095, 12'd0,    1'b1, 12'd0,    1'b1, 1'b0);
        vec12("ovf_pos",    12'd2047, 12'd1,    1'b0, 12'd2048, 1'b0, 1'b1);
        vec12("ovf_neg",    12'd2048, 12'd2048, 1'b0, 12'd0,    1'b1, 1'b1);
        vec12("carry_long", 12'd4095, 12'd4095, 1'b1, 12'd4095, 1'b1, 1'b0);

`ifdef ADDER_REG_OUT_EN
        // Reset wins over fresh operands on the same edge.
        rst  = 1'b1;
        a12  = 12'd2047;
        b12  = 12'd1;
        ci12 = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid", {50'd0, ov12, co12, s12}, 64'd0);
        rst    = 1'b0;
        prev12 = '0;
        vec12("after_rst",  12'd100,  12'd23,   1'b1, 12'd124,  1'b0, 1'b0);
`endif

        for (int i = 0; i < 10000; i++) begin
            a12  = 12'($urandom);
            b12  = 12'($urandom);
            ci12 = 1'($urandom);
            a1   = 1'($urandom);
            b1   = 1'($urandom);
            ci1  = 1'($urandom);
            a13  = 13'($urandom);
            b13  = 13'($urandom);
            ci13 = 1'($urandom);
            settle();
            check("rand_b12", {50'd0, ov12, co12, s12}, {50'd0, model12(a12, b12, ci12)});
            check("rand_b1",  {61'd0, ov1, co1, s1},    {61'd0, model1(a1, b1, ci1)});
            check("rand_b13", {49'd0, ov13, co13, s13}, {49'd0, model13(a13, b13, ci13)});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
